dmux8_distributor: RTL and testbench

DMUX8_DISTRIBUTOR -- requirements
Module: dmux8_distributor

---
 rtl/dmux_pkg.sv | 18 +
 rtl/dmux8_distributor_if.sv | 24 ++
 rtl/dec3_8.sv | 13 +
 rtl/dmux8_distributor.sv | 83 ++++++++
 tb/tb_dmux8_distributor.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dmux_pkg.sv
// Shared types and sizes for the 8-way serial-to-parallel distributor.
// Holds address width, output count, the frame state enum and a bit-select helper.
package dmux_pkg;

    localparam int ADDR_W = 3;
    localparam int N_OUT  = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    function automatic logic [N_OUT-1:0] bit_sel(input logic [ADDR_W-1:0] a);
        return N_OUT'(1) << a;
    endfunction

endpackage

// File: rtl/dmux8_distributor_if.sv
// Bus bundle for dmux8_distributor: En/S/D/Valid in, Yn/Q/Done out.
// master = stimulus side, slave = distributor side.
interface dmux8_distributor_if;
    import dmux_pkg::*;

    logic              En;
    logic [ADDR_W-1:0] S;
    logic              D;
    logic              Valid;
    logic [N_OUT-1:0]  Yn;
    logic [N_OUT-1:0]  Q;
    logic              Done;

    modport master (
        output En, S, D, Valid,
        input  Yn, Q, Done
    );

    modport slave (
        input  En, S, D, Valid,
        output Yn, Q, Done
    );

endinterface

// File: rtl/dec3_8.sv
// Combinational 3-to-8 active-low decoder with active-low enable.
// Ports: en_n (enable, low), a (address), y_n (one-hot-low, all ones when disabled).
module dec3_8
    import dmux_pkg::*;
(
    input  logic              en_n,
    input  logic [ADDR_W-1:0] a,
    output logic [N_OUT-1:0]  y_n
);

    assign y_n = en_n ? '1 : ~bit_sel(a);

endmodule

// File: rtl/dmux8_distributor.sv
// Serial bit distributor: writes D into a working byte at addr, publishes it on Q
// when all 8 bits are written, pulsing Done for one cycle. Ports: clk, rst
// (async, high), bus (slave modport: En, S, D, Valid -> Yn, Q, Done).
// Build option DMUX_AUTO_INC_EN: address from an internal wrapping counter, S ignored.
module dmux8_distributor
    import dmux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    dmux8_distributor_if.slave   bus
);

    state_t            state;
    logic [N_OUT-1:0]  w;
    logic [N_OUT-1:0]  m;
    logic [N_OUT-1:0]  q;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic [N_OUT-1:0]  sel;
    logic [N_OUT-1:0]  w_next;
    logic [N_OUT-1:0]  m_next;
    logic              wr;
    logic              complete;

`ifdef DMUX_AUTO_INC_EN
    logic [ADDR_W-1:0] cnt;
    logic              unused_s;

    assign unused_s = ^bus.S;
    assign addr     = cnt;
`else
    assign addr = bus.S;
`endif

    assign wr       = ~bus.En & bus.Valid;
    assign sel      = bit_sel(addr);
    assign w_next   = bus.D ? (w | sel) : (w & ~sel);
    assign m_next   = m | sel;
    // Completion uses the merged mask so the last bit lands on the same edge.
    assign complete = wr & (&m_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            w     <= '0;
            m     <= '0;
            q     <= '0;
            done  <= 1'b0;
`ifdef DMUX_AUTO_INC_EN
            cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (wr) begin
                w <= w_next;
`ifdef DMUX_AUTO_INC_EN
                cnt <= cnt + ADDR_W'(1);
`endif
                if (complete) begin
                    q     <= w_next;
                    m     <= '0;
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    m     <= m_next;
                    state <= FILL;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

    assign bus.Q    = q;
    assign bus.Done = done;

    dec3_8 u_dec (
        .en_n (bus.En),
        .a    (addr),
        .y_n  (bus.Yn)
    );

endmodule

// File: tb/tb_dmux8_distributor.sv
// Self-checking bench for dmux8_distributor (explicit or DMUX_AUTO_INC_EN build).
// Vector table plus scoreboard queue; hand sequence covers async reset.
module tb_dmux8_distributor;

`ifdef DMUX_AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        logic       en;
        logic [2:0] s;
        logic       d;
        logic       v;
        logic [7:0] q;
        logic       done;
        logic [7:0] yn;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       done;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    dmux8_distributor_if bus ();

    dmux8_distributor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic en, input logic [2:0] s, input logic d,
                                input logic v, input logic [7:0] q, input logic done,
                                input logic [7:0] yn);
        vec_t r;
        r = '{en, s, d, v, q, done, yn};
        tbl.push_back(r);
    endfunction

    task automatic step(input string nm, input logic en, input logic [2:0] s,
                        input logic d, input logic v, input logic [7:0] q,
                        input logic done, input logic [7:0] yn);
        exp_t e;
        bus.En    = en;
        bus.S     = s;
        bus.D     = d;
        bus.Valid = v;
        #2;
        chk({nm, " Yn"}, bus.Yn, yn);
        e = '{q, done, nm};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({e.nm, " Q"}, bus.Q, e.q);
            chk({e.nm, " Done"}, {7'b0, bus.Done}, {7'b0, e.done});
        end
    endtask

    initial begin
        logic [7:0] pat;
        logic [2:0] ss [8];
        logic [7:0] yn;

        // Table contents
`ifdef DMUX_AUTO_INC_EN
        pat = 8'h4D;
        for (int i = 0; i < 8; i++)
            add(0, 3'(7 - i), pat[i], 1, (i == 7) ? 8'h4D : 8'h00, i == 7, ~(8'h01 << i));
        add(0, 3, 0, 0, 8'h4D, 0, 8'hFE);
        add(0, 5, 1, 1, 8'h4D, 0, 8'hFE);
        add(0, 5, 0, 1, 8'h4D, 0, 8'hFD);
        for (int i = 0; i < 3; i++)
            add(1, 2, 1, 1, 8'h4D, 0, 8'hFF);
        for (int i = 2; i < 8; i++)
            add(0, 0, 1, 1, (i == 7) ? 8'hFD : 8'h4D, i == 7, ~(8'h01 << i));
        for (int i = 0; i < 16; i++)
            add(0, 0, i < 8, 1,
                (i < 7) ? 8'hFD : (i < 15) ? 8'hFF : 8'h00,
                (i == 7) || (i == 15), ~(8'h01 << (i % 8)));
`else
        add(0, 7, 1, 1, 8'h00, 0, 8'h7F);
        add(0, 6, 1, 1, 8'h00, 0, 8'hBF);
        add(0, 5, 1, 1, 8'h00, 0, 8'hDF);
        add(0, 4, 1, 1, 8'h00, 0, 8'hEF);
        add(0, 3, 1, 1, 8'h00, 0, 8'hF7);
        add(0, 3, 1, 1, 8'h00, 0, 8'hF7);
        add(0, 2, 1, 1, 8'h00, 0, 8'hFB);
        add(0, 1, 1, 1, 8'h00, 0, 8'hFD);
        add(0, 0, 1, 1, 8'hFF, 1, 8'hFE);
        add(0, 0, 0, 0, 8'hFF, 0, 8'hFE);
        add(0, 0, 1, 1, 8'hFF, 0, 8'hFE);
        add(0, 1, 1, 1, 8'hFF, 0, 8'hFD);
        add(0, 2, 1, 1, 8'hFF, 0, 8'hFB);
        add(0, 3, 1, 1, 8'hFF, 0, 8'hF7);
        add(0, 4, 0, 1, 8'hFF, 0, 8'hEF);
        add(0, 5, 0, 1, 8'hFF, 0, 8'hDF);
        add(0, 6, 1, 1, 8'hFF, 0, 8'hBF);
        add(0, 1, 0, 1, 8'hFF, 0, 8'hFD);
        add(1, 7, 1, 1, 8'hFF, 0, 8'hFF);
        add(1, 7, 1, 1, 8'hFF, 0, 8'hFF);
        add(1, 7, 1, 1, 8'hFF, 0, 8'hFF);
        add(0, 7, 0, 1, 8'h4D, 1, 8'h7F);
        for (int i = 0; i < 16; i++)
            add(0, 3'(i % 8), i < 8, 1,
                (i < 7) ? 8'h4D : (i < 15) ? 8'hFF : 8'h00,
                (i == 7) || (i == 15), ~(8'h01 << (i % 8)));
`endif

        // Reset state
        rst       = 1'b1;
        bus.En    = 1'b1;
        bus.S     = '0;
        bus.D     = 1'b0;
        bus.Valid = 1'b0;
        #12;
        chk("rst Q", bus.Q, 8'h00);
        chk("rst Done", {7'b0, bus.Done}, 8'h00);
        chk("rst Yn", bus.Yn, 8'hFF);
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < tbl.size(); k++)
            step($sformatf("v%0d", k), tbl[k].en, tbl[k].s, tbl[k].d, tbl[k].v,
                 tbl[k].q, tbl[k].done, tbl[k].yn);

        // Async reset mid-frame
        for (int i = 0; i < 8; i++)
            step($sformatf("r1_%0d", i), 0, 3'(i), 1, 1,
                 (i == 7) ? 8'hFF : 8'h00, i == 7, ~(8'h01 << i));
        for (int i = 0; i < 5; i++)
            step($sformatf("r2_%0d", i), 0, 3'(i), 0, 1, 8'hFF, 0, ~(8'h01 << i));
        bus.Valid = 1'b0;
        bus.S     = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst Q", bus.Q, 8'h00);
        chk("arst Done", {7'b0, bus.Done}, 8'h00);
        chk("arst Yn", bus.Yn, 8'hFE);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post rst Q", bus.Q, 8'h00);

        ss = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 8; i++) begin
            yn = AUTO ? ~(8'h01 << i) : ~(8'h01 << ss[i]);
            step($sformatf("r3_%0d", i), 0, ss[i], i < 3, 1,
                 (i < 7) ? 8'h00 : (AUTO ? 8'h07 : 8'hE0), i == 7, yn);
        end
        step("r4", 0, 0, 0, 0, AUTO ? 8'h07 : 8'hE0, 0, 8'hFE);

        chk("sb empty", 8'(sb.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
